i2c_arbiter: RTL and testbench
==============================

# i2c_arbiter

Two-port arbiter and sequencer that shares a single I2C generator (START_STB/RNW/TWOBYTE/I2C_ADDR/WR_DATA command interface) between two requesters. It latches the winning requester's command, strobes the generator, tracks the transaction on the generator's bus outputs by detecting START and STOP conditions, then returns read data and a completion pulse to the owner. It sits between the system-side requesters and the I2C generator; the generator itself is unchanged.

## Interface
Parameters:
- STB_CYCLES, 2, number of CLK cycles START_STB is held high per transaction (1..15)
- TIMEOUT, 255, CLK cycles allowed in WAIT_START or BUSY before abort (8-bit counter; used only with I2C_ARB_TIMEOUT_EN)

Ports:
- CLK  in  1  single clock, all logic on rising edge
- RESET  in  1  synchronous, active-low reset
- REQ0, REQ1  in  1  transaction request, level, held until DONEx
- RNW0, RNW1  in  1  read-not-write for requester x
- TWOBYTE0, TWOBYTE1  in  1  two-byte transfer for requester x
- I2C_ADDR0, I2C_ADDR1  in  7  target address for requester x
- WR_DATA0, WR_DATA1  in  16  write data for requester x
- GNT0, GNT1  out  1  requester x owns the generator (one-hot or zero)
- DONE0, DONE1  out  1  one-cycle completion pulse for requester x
- ERR  out  1  one-cycle abort pulse (timeout), coincident with DONEx
- RD_DATA_Q  out  16  RD_DATA captured at completion, held until next completion
- M_START_STB, M_RNW, M_TWOBYTE  out  1  to generator
- M_I2C_ADDR  out  7  to generator
- M_WR_DATA  out  16  to generator
- SDA_OUT, SDA_OE, SCL  in  1  generator bus outputs (monitored)
- RD_DATA  in  16  generator read data

## Operation
- States: IDLE, STROBE, WAIT_START, BUSY, DONE.
- IDLE: if any REQ high, pick winner; latch its RNW/TWOBYTE/I2C_ADDR/WR_DATA into M_* registers; assert GNTx; -> STROBE.
- Arbitration: round robin. LAST pointer resets to 1, so requester 0 wins the first tie. Single request always wins. LAST updates to winner on entry to DONE.
- STROBE: M_START_STB high for exactly STB_CYCLES cycles; -> WAIT_START.
- WAIT_START: wait for START event; -> BUSY.
- BUSY: wait for STOP event; -> DONE.
- DONE (1 cycle): pulse DONEx, load RD_DATA_Q from RD_DATA (all transactions, write included), deassert GNTx; -> IDLE.
- Bus event detect: register SCL_d, SDA_d each cycle. START = SCL & SCL_d & SDA_OE & SDA_d & !SDA_OUT. STOP = SCL & SCL_d & SDA_OE & !SDA_d & SDA_OUT.
- Command M_* outputs stable from GNT rise until next grant; requester inputs ignored after latch.
- REQ dropped mid-transaction: ignored; transaction completes, DONEx still pulses.
- STOP seen in WAIT_START: ignored. START seen in BUSY (repeated start): ignored, remain BUSY.

## Timing
- Reset (RESET=0 at rising edge): state IDLE, LAST=1, all outputs 0 including RD_DATA_Q and M_*; takes effect next edge, also mid-transaction (M_START_STB drops immediately, no DONE/ERR).
- Grant latency: REQ sampled high in IDLE at edge n -> GNTx and M_START_STB high after edge n, M_* valid same cycle.
- M_START_STB high cycles n+1..n+STB_CYCLES.
- STOP detected at edge k -> DONEx high cycle k+1 only; GNTx low from cycle k+2.
- At least one IDLE cycle between transactions; a requester holding REQ through DONEx receives a second transaction.
- Both REQ high continuously: grants alternate 0,1,0,1.

## Configuration
- I2C_ARB_TIMEOUT_EN defined: cycle counter cleared on entry to WAIT_START and BUSY; reaching TIMEOUT -> DONE with ERR=1 alongside DONEx, RD_DATA_Q loaded anyway.
- Undefined: no counter; ERR tied 0; arbiter waits indefinitely for START/STOP.

## Test plan
- Reset: hold RESET=0 for 2 cycles with REQ0=1 -> all outputs 0, no GNT; release -> GNT0 next cycle.
- Single write: REQ0, I2C_ADDR0=7'b0011010, WR_DATA0=16'hAAAE, TWOBYTE0=1 -> M_I2C_ADDR=0x1A, M_WR_DATA=0xAAAE, M_START_STB high 2 cycles, DONE0 one cycle after generator STOP.
- Read: REQ1, RNW1=1, generator returns RD_DATA=16'h5A3C -> RD_DATA_Q=0x5A3C with DONE1, held afterwards.
- Contention: REQ0 and REQ1 asserted same cycle and held for 4 transactions -> grant order 0,1,0,1, never both GNT high.
- Reset mid-BUSY: drop RESET while BUSY -> IDLE, GNT low, no DONE pulse.
- With I2C_ARB_TIMEOUT_EN, TIMEOUT=20, generator never emits START -> ERR and DONE0 together 20 cycles after WAIT_START entry; without macro, GNT0 remains high.

Source files
------------

// File: rtl/i2c_arbiter_if.sv
// ----------------------------------------------------------------------------
// i2c_arbiter_if
// Signal bundle between two requesters, the arbiter and the shared I2C
// generator.
//   slave  modport : arbiter view (requester commands and generator bus
//                    outputs in; grants, completions, read data and the
//                    generator command out)
//   master modport : environment view (requesters plus the generator)
// Requester side : REQx, RNWx, TWOBYTEx, I2C_ADDRx, WR_DATAx -> GNTx, DONEx,
//                  ERR, RD_DATA_Q
// Generator side : M_START_STB, M_RNW, M_TWOBYTE, M_I2C_ADDR, M_WR_DATA ->
//                  SDA_OUT, SDA_OE, SCL, RD_DATA
// ----------------------------------------------------------------------------
interface i2c_arbiter_if;
    logic        REQ0, REQ1;
    logic        RNW0, RNW1;
    logic        TWOBYTE0, TWOBYTE1;
    logic [6:0]  I2C_ADDR0, I2C_ADDR1;
    logic [15:0] WR_DATA0, WR_DATA1;
    logic        GNT0, GNT1;
    logic        DONE0, DONE1;
    logic        ERR;
    logic [15:0] RD_DATA_Q;
    logic        M_START_STB, M_RNW, M_TWOBYTE;
    logic [6:0]  M_I2C_ADDR;
    logic [15:0] M_WR_DATA;
    logic        SDA_OUT, SDA_OE, SCL;
    logic [15:0] RD_DATA;

    modport slave (
        input  REQ0, REQ1, RNW0, RNW1, TWOBYTE0, TWOBYTE1,
               I2C_ADDR0, I2C_ADDR1, WR_DATA0, WR_DATA1,
               SDA_OUT, SDA_OE, SCL, RD_DATA,
        output GNT0, GNT1, DONE0, DONE1, ERR, RD_DATA_Q,
               M_START_STB, M_RNW, M_TWOBYTE, M_I2C_ADDR, M_WR_DATA
    );

    modport master (
        output REQ0, REQ1, RNW0, RNW1, TWOBYTE0, TWOBYTE1,
               I2C_ADDR0, I2C_ADDR1, WR_DATA0, WR_DATA1,
               SDA_OUT, SDA_OE, SCL, RD_DATA,
        input  GNT0, GNT1, DONE0, DONE1, ERR, RD_DATA_Q,
               M_START_STB, M_RNW, M_TWOBYTE, M_I2C_ADDR, M_WR_DATA
    );
endinterface

// File: rtl/i2c_arbiter.sv
// ----------------------------------------------------------------------------
// i2c_arbiter
// Shares one I2C generator between two requesters. The winner's command is
// latched into the M_* registers, the generator is strobed for STB_CYCLES
// clocks, and the transaction is followed on the generator's bus outputs
// (START then STOP). On STOP the owner gets a one-cycle DONE pulse and
// RD_DATA is captured into RD_DATA_Q.
// Ports:
//   CLK   : clock, rising edge
//   RESET : synchronous, active-low
//   bus   : i2c_arbiter_if.slave (requester and generator signals)
// Parameters:
//   STB_CYCLES : M_START_STB high time in clocks (1..15)
//   TIMEOUT    : abort limit in WAIT_START/BUSY (only with I2C_ARB_TIMEOUT_EN)
// Optional feature macro: I2C_ARB_TIMEOUT_EN enables the abort counter and
// ERR; without it ERR is constant 0 and the arbiter waits indefinitely.
// ----------------------------------------------------------------------------
module i2c_arbiter #(
    parameter int STB_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input logic          CLK,
    input logic          RESET,
    i2c_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_STROBE, ST_WAIT_START, ST_BUSY, ST_DONE
    } state_t;

    localparam logic [3:0] STB_LAST = 4'(STB_CYCLES);

    state_t      state_reg, state_next;
    logic [1:0]  gnt_reg, gnt_next;
    logic [1:0]  done_reg, done_next;
    logic        err_reg, err_next;
    logic        last_reg, last_next;
    logic        owner_reg, owner_next;
    logic        stb_reg, stb_next;
    logic [3:0]  stb_cnt_reg, stb_cnt_next;
    logic        m_rnw_reg, m_rnw_next;
    logic        m_two_reg, m_two_next;
    logic [6:0]  m_addr_reg, m_addr_next;
    logic [15:0] m_wdata_reg, m_wdata_next;
    logic [15:0] rd_q_reg, rd_q_next;
    logic        scl_d_reg, sda_d_reg;

    logic [1:0]  req_vec;
    logic        win;
    logic        start_evt, stop_evt;
    logic        timeout;

    assign req_vec = {bus.REQ1, bus.REQ0};

    // Round robin: on a tie the requester that did not finish last wins.
    always_comb begin
        if (req_vec == 2'b11) win = ~last_reg;
        else                  win = req_vec[1];
    end

    // START: SDA falls while SCL stays high; STOP: SDA rises while SCL high.
    assign start_evt = bus.SCL & scl_d_reg & bus.SDA_OE & sda_d_reg & ~bus.SDA_OUT;
    assign stop_evt  = bus.SCL & scl_d_reg & bus.SDA_OE & ~sda_d_reg & bus.SDA_OUT;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_cnt_reg;

    // Cleared whenever WAIT_START or BUSY is entered; counts while in them.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            tmo_cnt_reg <= '0;
        end else if (state_next != state_reg) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == ST_WAIT_START || state_reg == ST_BUSY) begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
        end
    end

    assign timeout = (tmo_cnt_reg == TMO_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        done_next    = 2'b00;
        err_next     = 1'b0;
        last_next    = last_reg;
        owner_next   = owner_reg;
        stb_next     = stb_reg;
        stb_cnt_next = stb_cnt_reg;
        m_rnw_next   = m_rnw_reg;
        m_two_next   = m_two_reg;
        m_addr_next  = m_addr_reg;
        m_wdata_next = m_wdata_reg;
        rd_q_next    = rd_q_reg;

        case (state_reg)
            ST_IDLE: begin
                if (|req_vec) begin
                    owner_next   = win;
                    gnt_next     = win ? 2'b10 : 2'b01;
                    m_rnw_next   = win ? bus.RNW1      : bus.RNW0;
                    m_two_next   = win ? bus.TWOBYTE1  : bus.TWOBYTE0;
                    m_addr_next  = win ? bus.I2C_ADDR1 : bus.I2C_ADDR0;
                    m_wdata_next = win ? bus.WR_DATA1  : bus.WR_DATA0;
                    stb_next     = 1'b1;
                    stb_cnt_next = 4'd1;
                    state_next   = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (stb_cnt_reg == STB_LAST) begin
                    stb_next   = 1'b0;
                    state_next = ST_WAIT_START;
                end else begin
                    stb_cnt_next = stb_cnt_reg + 4'd1;
                end
            end
            ST_WAIT_START: begin
                if (start_evt) begin
                    state_next = ST_BUSY;
                end else if (timeout) begin
                    state_next = ST_DONE;
                    err_next   = 1'b1;
                end
            end
            ST_BUSY: begin
                if (stop_evt) begin
                    state_next = ST_DONE;
                end else if (timeout) begin
                    state_next = ST_DONE;
                    err_next   = 1'b1;
                end
            end
            ST_DONE: begin
                gnt_next   = 2'b00;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // Entry into DONE: registered completion pulse, read capture and
        // round-robin pointer update all happen on the same edge.
        if (state_next == ST_DONE && state_reg != ST_DONE) begin
            done_next = owner_reg ? 2'b10 : 2'b01;
            rd_q_next = bus.RD_DATA;
            last_next = owner_reg;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg   <= ST_IDLE;
            gnt_reg     <= 2'b00;
            done_reg    <= 2'b00;
            err_reg     <= 1'b0;
            last_reg    <= 1'b1;
            owner_reg   <= 1'b0;
            stb_reg     <= 1'b0;
            stb_cnt_reg <= 4'd0;
            m_rnw_reg   <= 1'b0;
            m_two_reg   <= 1'b0;
            m_addr_reg  <= 7'd0;
            m_wdata_reg <= 16'd0;
            rd_q_reg    <= 16'd0;
            scl_d_reg   <= 1'b0;
            sda_d_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            last_reg    <= last_next;
            owner_reg   <= owner_next;
            stb_reg     <= stb_next;
            stb_cnt_reg <= stb_cnt_next;
            m_rnw_reg   <= m_rnw_next;
            m_two_reg   <= m_two_next;
            m_addr_reg  <= m_addr_next;
            m_wdata_reg <= m_wdata_next;
            rd_q_reg    <= rd_q_next;
            scl_d_reg   <= bus.SCL;
            sda_d_reg   <= bus.SDA_OUT;
        end
    end

    assign bus.GNT0        = gnt_reg[0];
    assign bus.GNT1        = gnt_reg[1];
    assign bus.DONE0       = done_reg[0];
    assign bus.DONE1       = done_reg[1];
    assign bus.ERR         = err_reg;
    assign bus.RD_DATA_Q   = rd_q_reg;
    assign bus.M_START_STB = stb_reg;
    assign bus.M_RNW       = m_rnw_reg;
    assign bus.M_TWOBYTE   = m_two_reg;
    assign bus.M_I2C_ADDR  = m_addr_reg;
    assign bus.M_WR_DATA   = m_wdata_reg;
endmodule

// File: tb/tb_i2c_arbiter.sv
// ----------------------------------------------------------------------------
// tb_i2c_arbiter
// Directed bench for i2c_arbiter: reset, single write, read with ignored bus
// events, round-robin contention, reset mid-transaction and the timeout
// behaviour (build dependent on I2C_ARB_TIMEOUT_EN). Inputs are driven and
// outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_i2c_arbiter;
    logic CLK = 1'b0;
    logic RESET;
    int total = 0;
    int bad = 0;

    i2c_arbiter_if bus ();

    i2c_arbiter #(.STB_CYCLES(2), .TIMEOUT(20)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    // Generator model: SDA falls with SCL high, then SCL goes low.
    task automatic bus_start();
        bus.SDA_OUT = 1'b0;
        tick(1);
        bus.SCL = 1'b0;
        tick(1);
    endtask

    // Bring SCL high with SDA low; caller then raises SDA to make STOP.
    task automatic bus_stop_arm();
        bus.SDA_OUT = 1'b0;
        bus.SCL     = 1'b1;
        tick(1);
    endtask

    task automatic bus_idle();
        bus.SDA_OE  = 1'b1;
        bus.SCL     = 1'b1;
        tick(1);
        bus.SDA_OUT = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        bus.REQ0 = 1'b1;
        tick(2);
        total++;
        if ({bus.GNT0, bus.GNT1, bus.DONE0, bus.DONE1, bus.ERR, bus.M_START_STB,
             bus.M_RNW, bus.M_TWOBYTE} !== 8'h00) begin
            bad++;
            $display("FAIL reset_flags got=%b want=00000000",
                     {bus.GNT0, bus.GNT1, bus.DONE0, bus.DONE1, bus.ERR,
                      bus.M_START_STB, bus.M_RNW, bus.M_TWOBYTE});
        end
        total++;
        if ({bus.RD_DATA_Q, bus.M_WR_DATA, bus.M_I2C_ADDR} !== 39'd0) begin
            bad++;
            $display("FAIL reset_data got q=%h wd=%h a=%h want 0",
                     bus.RD_DATA_Q, bus.M_WR_DATA, bus.M_I2C_ADDR);
        end
        RESET = 1'b1;
        tick(1);
        total++;
        if (bus.GNT0 !== 1'b1 || bus.GNT1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_gnt got=%b%b want=10", bus.GNT0, bus.GNT1);
        end
        RESET = 1'b0;
        bus.REQ0 = 1'b0;
        tick(1);
        RESET = 1'b1;
        $display("txn reset: grant after release observed, reset again");
        tick(1);
    endtask

    task automatic test_single_write();
        bus.RNW0 = 1'b0; bus.TWOBYTE0 = 1'b1;
        bus.I2C_ADDR0 = 7'b0011010; bus.WR_DATA0 = 16'hAAAE;
        bus.REQ0 = 1'b1;
        tick(1);
        total++;
        if ({bus.GNT0, bus.GNT1, bus.M_START_STB, bus.M_RNW, bus.M_TWOBYTE} !== 5'b10101) begin
            bad++;
            $display("FAIL wr_grant got=%b want=10101",
                     {bus.GNT0, bus.GNT1, bus.M_START_STB, bus.M_RNW, bus.M_TWOBYTE});
        end
        total++;
        if (bus.M_I2C_ADDR !== 7'h1A || bus.M_WR_DATA !== 16'hAAAE) begin
            bad++;
            $display("FAIL wr_cmd got a=%h d=%h want a=1a d=aaae",
                     bus.M_I2C_ADDR, bus.M_WR_DATA);
        end
        bus.I2C_ADDR0 = 7'h55;
        bus.WR_DATA0  = 16'h0000;
        tick(1);
        total++;
        if (bus.M_START_STB !== 1'b1 || bus.M_I2C_ADDR !== 7'h1A) begin
            bad++;
            $display("FAIL wr_stb2 got stb=%b a=%h want stb=1 a=1a",
                     bus.M_START_STB, bus.M_I2C_ADDR);
        end
        tick(1);
        total++;
        if (bus.M_START_STB !== 1'b0) begin
            bad++;
            $display("FAIL wr_stb_end got=%b want=0", bus.M_START_STB);
        end
        bus_start();
        bus.RD_DATA = 16'h1234;
        bus_stop_arm();
        total++;
        if (bus.DONE0 !== 1'b0 || bus.GNT0 !== 1'b1) begin
            bad++;
            $display("FAIL wr_busy got done=%b gnt=%b want done=0 gnt=1",
                     bus.DONE0, bus.GNT0);
        end
        bus.SDA_OUT = 1'b1;
        tick(1);
        total++;
        if (bus.DONE0 !== 1'b1 || bus.GNT0 !== 1'b1 || bus.RD_DATA_Q !== 16'h1234) begin
            bad++;
            $display("FAIL wr_done got done=%b gnt=%b q=%h want done=1 gnt=1 q=1234",
                     bus.DONE0, bus.GNT0, bus.RD_DATA_Q);
        end
        bus.REQ0 = 1'b0;
        tick(1);
        total++;
        if (bus.DONE0 !== 1'b0 || bus.GNT0 !== 1'b0) begin
            bad++;
            $display("FAIL wr_after got done=%b gnt=%b want 0 0", bus.DONE0, bus.GNT0);
        end
        $display("txn write: req0 addr=1a data=aaae complete");
    endtask

    task automatic test_read();
        bus.RNW1 = 1'b1; bus.TWOBYTE1 = 1'b0;
        bus.I2C_ADDR1 = 7'h48; bus.WR_DATA1 = 16'h0001;
        bus.REQ1 = 1'b1;
        tick(1);
        total++;
        if ({bus.GNT0, bus.GNT1, bus.M_RNW, bus.M_TWOBYTE} !== 4'b0110 ||
            bus.M_I2C_ADDR !== 7'h48) begin
            bad++;
            $display("FAIL rd_grant got=%b a=%h want=0110 a=48",
                     {bus.GNT0, bus.GNT1, bus.M_RNW, bus.M_TWOBYTE}, bus.M_I2C_ADDR);
        end
        tick(2);
        // STOP-shaped event before any START: must be ignored.
        bus.SDA_OE = 1'b0; bus.SDA_OUT = 1'b0;
        tick(1);
        bus.SDA_OE = 1'b1;
        tick(1);
        bus.SDA_OUT = 1'b1;
        tick(2);
        total++;
        if (bus.DONE1 !== 1'b0 || bus.GNT1 !== 1'b1) begin
            bad++;
            $display("FAIL rd_stop_in_wait got done=%b gnt=%b want 0 1",
                     bus.DONE1, bus.GNT1);
        end
        bus_start();
        // Repeated START while busy: must be ignored.
        bus.SDA_OUT = 1'b1;
        tick(1);
        bus.SCL = 1'b1;
        tick(1);
        bus_start();
        total++;
        if (bus.DONE1 !== 1'b0 || bus.GNT1 !== 1'b1) begin
            bad++;
            $display("FAIL rd_rep_start got done=%b gnt=%b want 0 1",
                     bus.DONE1, bus.GNT1);
        end
        bus.RD_DATA = 16'h5A3C;
        bus_stop_arm();
        bus.SDA_OUT = 1'b1;
        tick(1);
        total++;
        if (bus.DONE1 !== 1'b1 || bus.DONE0 !== 1'b0 || bus.RD_DATA_Q !== 16'h5A3C) begin
            bad++;
            $display("FAIL rd_done got d1=%b d0=%b q=%h want 1 0 5a3c",
                     bus.DONE1, bus.DONE0, bus.RD_DATA_Q);
        end
        bus.REQ1 = 1'b0;
        bus.RD_DATA = 16'hFFFF;
        tick(3);
        total++;
        if (bus.RD_DATA_Q !== 16'h5A3C || bus.GNT1 !== 1'b0) begin
            bad++;
            $display("FAIL rd_hold got q=%h gnt=%b want 5a3c 0", bus.RD_DATA_Q, bus.GNT1);
        end
        $display("txn read: req1 addr=48 data=5a3c complete");
    endtask

    task automatic test_contention();
        int n;
        logic exp_owner;
        bus.REQ0 = 1'b1;
        bus.REQ1 = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_owner = t[0];
            n = 0;
            while (!(bus.GNT0 | bus.GNT1) && n < 20) begin
                tick(1);
                n++;
            end
            total++;
            if ({bus.GNT1, bus.GNT0} !== (exp_owner ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL rr_order t=%0d got gnt1,gnt0=%b%b want owner %0d",
                         t, bus.GNT1, bus.GNT0, exp_owner);
            end
            tick(2);
            bus_start();
            bus_stop_arm();
            bus.SDA_OUT = 1'b1;
            n = 0;
            while (!(bus.DONE0 | bus.DONE1) && n < 20) begin
                tick(1);
                total++;
                if (bus.GNT0 & bus.GNT1) begin
                    bad++;
                    $display("FAIL rr_both_gnt t=%0d got 11 want one-hot", t);
                end
                n++;
            end
            total++;
            if ({bus.DONE1, bus.DONE0} !== (exp_owner ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL rr_done t=%0d got done1,done0=%b%b want owner %0d",
                         t, bus.DONE1, bus.DONE0, exp_owner);
            end
            if (t == 3) begin
                bus.REQ0 = 1'b0;
                bus.REQ1 = 1'b0;
            end
            tick(1);
            total++;
            if (bus.GNT0 !== 1'b0 || bus.GNT1 !== 1'b0) begin
                bad++;
                $display("FAIL rr_idle_gap t=%0d got=%b%b want=00", t, bus.GNT0, bus.GNT1);
            end
            $display("txn contention: t=%0d owner=%0d", t, exp_owner);
        end
        tick(2);
    endtask

    task automatic test_reset_busy();
        bus.REQ0 = 1'b1;
        tick(3);
        bus_start();
        RESET = 1'b0;
        bus.REQ0 = 1'b0;
        tick(1);
        RESET = 1'b1;
        total++;
        if ({bus.GNT0, bus.DONE0, bus.ERR, bus.M_START_STB} !== 4'b0000 ||
            bus.RD_DATA_Q !== 16'h0000) begin
            bad++;
            $display("FAIL rst_busy got=%b q=%h want=0000 q=0000",
                     {bus.GNT0, bus.DONE0, bus.ERR, bus.M_START_STB}, bus.RD_DATA_Q);
        end
        bus_stop_arm();
        bus.SDA_OUT = 1'b1;
        tick(2);
        total++;
        if (bus.DONE0 !== 1'b0 || bus.GNT0 !== 1'b0) begin
            bad++;
            $display("FAIL rst_busy_after got done=%b gnt=%b want 0 0", bus.DONE0, bus.GNT0);
        end
        $display("txn reset-busy: transaction aborted silently");
    endtask

    task automatic test_timeout();
        bus.REQ0 = 1'b1;
        tick(3);   // now in the first WAIT_START cycle
`ifdef I2C_ARB_TIMEOUT_EN
        for (int i = 1; i < 20; i++) begin
            tick(1);
            total++;
            if (bus.DONE0 !== 1'b0) begin
                bad++;
                $display("FAIL tmo_early i=%0d got done=1 want 0", i);
            end
        end
        bus.RD_DATA = 16'hBEEF;
        tick(1);
        total++;
        if (bus.DONE0 !== 1'b1 || bus.ERR !== 1'b1 || bus.RD_DATA_Q !== 16'hBEEF) begin
            bad++;
            $display("FAIL tmo_abort got done=%b err=%b q=%h want 1 1 beef",
                     bus.DONE0, bus.ERR, bus.RD_DATA_Q);
        end
        bus.REQ0 = 1'b0;
        tick(2);
        $display("txn timeout: aborted with ERR");
`else
        tick(40);
        total++;
        if (bus.GNT0 !== 1'b1 || bus.DONE0 !== 1'b0 || bus.ERR !== 1'b0) begin
            bad++;
            $display("FAIL no_tmo got gnt=%b done=%b err=%b want 1 0 0",
                     bus.GNT0, bus.DONE0, bus.ERR);
        end
        RESET = 1'b0;
        bus.REQ0 = 1'b0;
        tick(1);
        RESET = 1'b1;
        $display("txn timeout: disabled build keeps waiting");
`endif
    endtask

    initial begin
        RESET = 1'b0;
        bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
        bus.RNW0 = 1'b0; bus.RNW1 = 1'b0;
        bus.TWOBYTE0 = 1'b0; bus.TWOBYTE1 = 1'b0;
        bus.I2C_ADDR0 = 7'h1A; bus.I2C_ADDR1 = 7'h00;
        bus.WR_DATA0 = 16'hAAAE; bus.WR_DATA1 = 16'h0000;
        bus.SDA_OUT = 1'b1; bus.SDA_OE = 1'b1; bus.SCL = 1'b1;
        bus.RD_DATA = 16'h0000;
        test_reset();
        test_single_write();
        test_read();
        test_contention();
        test_reset_busy();
        bus_idle();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
